// File: rtl/lab06_arb_pkg.sv
// Shared types and constants for the lab06 round-robin arbiter.
package lab06_arb_pkg;

   localparam int unsigned NUM_W     = 4;
   localparam int unsigned MODE_W    = 2;
   localparam int unsigned RES_W     = 7;
   // Beat buffer is sized for the largest legal burst; cnt indexes it directly.
   localparam int unsigned MAX_BURST = 8;
   localparam int unsigned CNT_W     = 3;

   // Substitute result returned when the engine never answers (-64).
   localparam logic signed [RES_W-1:0] RES_TIMEOUT = 7'sb100_0000;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSend,
      StWait,
      StResp
   } arb_state_e;

endpackage

// File: rtl/lab06_rr_pick.sv
// Combinational circular priority picker: first asserted req at or after ptr.
module lab06_rr_pick #(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   output logic            gnt_valid,
   output logic [1:0]      gnt_idx
);

   // Padding to four entries lets a 2-bit index address any legal NREQ.
   logic [3:0] req_pad;
   logic [1:0] cand;

   assign req_pad = 4'(req);

   // Scan NREQ candidates starting at ptr, wrapping modulo NREQ.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = 2'((32'(ptr) + k) % NREQ);
         if (!gnt_valid && req_pad[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/lab06_arbiter.sv
// Round-robin scheduler sharing one lab06 compute engine between NREQ requesters.
// Optional engine-response watchdog: define LAB06_ARB_TIMEOUT_EN.
module lab06_arbiter
   import lab06_arb_pkg::*;
#(
   parameter int unsigned NREQ      = 2,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          rq_valid,
   output logic [NREQ-1:0]          rq_ready,
   input  logic [NREQ*NUM_W-1:0]    rq_number,
   input  logic [NREQ*MODE_W-1:0]   rq_mode,
   output logic [NREQ-1:0]          rsp_valid,
   output logic signed [RES_W-1:0]  rsp_result,
   output logic                     rsp_err,
   output logic                     eng_in_valid,
   output logic [NUM_W-1:0]         eng_in_number,
   output logic [MODE_W-1:0]        eng_mode,
   input  logic                     eng_out_valid,
   input  logic signed [RES_W-1:0]  eng_out_result,
   output logic                     busy,
   output logic [1:0]               owner
);

   if (NREQ < 2 || NREQ > 4 || BURST_LEN < 2 || BURST_LEN > MAX_BURST || TIMEOUT < 1)
   begin : g_param_check
      $error("lab06_arbiter: parameter out of range");
   end

   arb_state_e               state_q, state_d;
   logic [1:0]               owner_q, owner_d;
   logic [1:0]               ptr_q, ptr_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [MODE_W-1:0]        mode_q, mode_d;
   logic [NREQ-1:0]          rq_ready_q, rq_ready_d;
   logic [NREQ-1:0]          rsp_valid_q, rsp_valid_d;
   logic signed [RES_W-1:0]  rsp_result_q, rsp_result_d;
   logic                     eng_in_valid_q, eng_in_valid_d;
   logic [NUM_W-1:0]         eng_in_number_q, eng_in_number_d;
   logic [MODE_W-1:0]        eng_mode_q, eng_mode_d;
   logic                     busy_q, busy_d;

   logic [NUM_W-1:0]         beat_q [MAX_BURST];
   logic                     beat_we;
   logic [NUM_W-1:0]         beat_wdata;

`ifdef LAB06_ARB_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
   logic [TmoW-1:0]          wait_cnt_q, wait_cnt_d;
   logic                     rsp_err_q, rsp_err_d;
`endif

   // Requester buses padded to four lanes so the 2-bit owner indexes them directly.
   logic [3:0]               rq_valid_pad;
   logic [4*NUM_W-1:0]       rq_num_pad;
   logic [4*MODE_W-1:0]      rq_mode_pad;

   assign rq_valid_pad = 4'(rq_valid);
   assign rq_num_pad   = (4 * NUM_W)'(rq_number);
   assign rq_mode_pad  = (4 * MODE_W)'(rq_mode);

   logic       gnt_valid;
   logic [1:0] gnt_idx;

   lab06_rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req       (rq_valid),
      .ptr       (ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Next-state and registered-output computation for the whole job sequence.
   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      ptr_d           = ptr_q;
      cnt_d           = cnt_q;
      mode_d          = mode_q;
      rq_ready_d      = rq_ready_q;
      rsp_valid_d     = '0;
      rsp_result_d    = '0;
      eng_in_valid_d  = 1'b0;
      eng_in_number_d = '0;
      eng_mode_d      = '0;
      beat_we         = 1'b0;
      beat_wdata      = rq_num_pad[{owner_q, 2'b00} +: NUM_W];
`ifdef LAB06_ARB_TIMEOUT_EN
      wait_cnt_d      = '0;
      rsp_err_d       = 1'b0;
`endif

      unique case (state_q)
         StIdle: begin
            if (gnt_valid) begin
               owner_d    = gnt_idx;
               rq_ready_d = NREQ'(4'b0001 << gnt_idx);
               state_d    = StLoad;
            end
         end
         StLoad: begin
            if (rq_valid_pad[owner_q]) begin
               beat_we = 1'b1;
               if (cnt_q == '0) begin
                  mode_d = rq_mode_pad[{owner_q, 1'b0} +: MODE_W];
               end
               if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                  // Beat 0 is already buffered, so it goes out on the very next cycle.
                  rq_ready_d      = '0;
                  state_d         = StSend;
                  eng_in_valid_d  = 1'b1;
                  eng_in_number_d = beat_q[0];
                  eng_mode_d      = mode_q;
                  cnt_d           = CNT_W'(1);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         StSend: begin
            // cnt wraps to 0 once the final beat is issued, marking the burst end.
            if (cnt_q == '0) begin
               state_d = StWait;
            end else begin
               eng_in_valid_d  = 1'b1;
               eng_in_number_d = beat_q[cnt_q];
               eng_mode_d      = mode_q;
               cnt_d           = (cnt_q == CNT_W'(BURST_LEN - 1)) ? '0 : cnt_q + CNT_W'(1);
            end
         end
         StWait: begin
            if (eng_out_valid) begin
               rsp_valid_d  = NREQ'(4'b0001 << owner_q);
               rsp_result_d = eng_out_result;
               state_d      = StResp;
`ifdef LAB06_ARB_TIMEOUT_EN
            end else if (wait_cnt_q == TmoW'(TIMEOUT - 1)) begin
               rsp_valid_d  = NREQ'(4'b0001 << owner_q);
               rsp_result_d = RES_TIMEOUT;
               rsp_err_d    = 1'b1;
               state_d      = StResp;
            end else begin
               wait_cnt_d = wait_cnt_q + TmoW'(1);
`endif
            end
         end
         StResp: begin
            ptr_d   = (owner_q == 2'(NREQ - 1)) ? 2'd0 : owner_q + 2'd1;
            owner_d = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   // FSM state and every registered output, with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         owner_q         <= '0;
         ptr_q           <= '0;
         cnt_q           <= '0;
         mode_q          <= '0;
         rq_ready_q      <= '0;
         rsp_valid_q     <= '0;
         rsp_result_q    <= '0;
         eng_in_valid_q  <= 1'b0;
         eng_in_number_q <= '0;
         eng_mode_q      <= '0;
         busy_q          <= 1'b0;
`ifdef LAB06_ARB_TIMEOUT_EN
         wait_cnt_q      <= '0;
         rsp_err_q       <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         ptr_q           <= ptr_d;
         cnt_q           <= cnt_d;
         mode_q          <= mode_d;
         rq_ready_q      <= rq_ready_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_result_q    <= rsp_result_d;
         eng_in_valid_q  <= eng_in_valid_d;
         eng_in_number_q <= eng_in_number_d;
         eng_mode_q      <= eng_mode_d;
         busy_q          <= busy_d;
`ifdef LAB06_ARB_TIMEOUT_EN
         wait_cnt_q      <= wait_cnt_d;
         rsp_err_q       <= rsp_err_d;
`endif
      end
   end

   // Beat buffer; contents are don't-care after reset so it carries no reset.
   always_ff @(posedge clk) begin
      if (beat_we) begin
         beat_q[cnt_q] <= beat_wdata;
      end
   end

   assign rq_ready      = rq_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_result    = rsp_result_q;
   assign eng_in_valid  = eng_in_valid_q;
   assign eng_in_number = eng_in_number_q;
   assign eng_mode      = eng_mode_q;
   assign busy          = busy_q;
   assign owner         = owner_q;
`ifdef LAB06_ARB_TIMEOUT_EN
   assign rsp_err       = rsp_err_q;
`else
   assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_lab06_arbiter.sv
// Scoreboard bench for lab06_arbiter with a behavioural engine (result = sum of beats).
// Timeout scenarios run only when LAB06_ARB_TIMEOUT_EN is defined.
module tb_lab06_arbiter;

   localparam int NREQ = 2;
   localparam int BL   = 4;
   localparam int TMO  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic                req_v [NREQ];
   logic [3:0]          req_n [NREQ];
   logic [1:0]          req_m [NREQ];
   logic [NREQ-1:0]     rq_valid;
   logic [NREQ*4-1:0]   rq_number;
   logic [NREQ*2-1:0]   rq_mode;
   logic [NREQ-1:0]     rq_ready;
   logic [NREQ-1:0]     rsp_valid;
   logic signed [6:0]   rsp_result;
   logic                rsp_err;
   logic                eng_in_valid;
   logic [3:0]          eng_in_number;
   logic [1:0]          eng_mode;
   logic                eng_out_valid;
   logic signed [6:0]   eng_out_result;
   logic                busy;
   logic [1:0]          owner;

   assign rq_valid  = {req_v[1], req_v[0]};
   assign rq_number = {req_n[1], req_n[0]};
   assign rq_mode   = {req_m[1], req_m[0]};

   lab06_arbiter #(
      .NREQ      (NREQ),
      .BURST_LEN (BL),
      .TIMEOUT   (TMO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rq_valid       (rq_valid),
      .rq_ready       (rq_ready),
      .rq_number      (rq_number),
      .rq_mode        (rq_mode),
      .rsp_valid      (rsp_valid),
      .rsp_result     (rsp_result),
      .rsp_err        (rsp_err),
      .eng_in_valid   (eng_in_valid),
      .eng_in_number  (eng_in_number),
      .eng_mode       (eng_mode),
      .eng_out_valid  (eng_out_valid),
      .eng_out_result (eng_out_result),
      .busy           (busy),
      .owner          (owner)
   );

   typedef struct {
      logic [15:0] nums;
      logic [1:0]  mode;
   } beat_t;

   typedef struct {
      int                idx;
      logic signed [6:0] res;
      logic              err;
   } rsp_t;

   beat_t exp_beats [$];
   rsp_t  exp_rsp [$];

   int total = 0;
   int bad   = 0;

   int                eng_lat      = 2;
   bit                eng_silent   = 1'b0;
   bit                ovr_en       = 1'b0;
   logic signed [6:0] ovr_val      = '0;
   int                last_acc_cyc = 0;
   int                last_eov_cyc = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic signed [6:0] sum_of(input logic [15:0] n);
      logic signed [6:0] s;
      s = '0;
      for (int b = 0; b < BL; b++) s = s + 7'(n[4*b +: 4]);
      return s;
   endfunction

   task automatic push_job(input int r, input logic [15:0] n, input logic [1:0] m,
                           input logic signed [6:0] res, input logic err);
      beat_t bt;
      rsp_t  rs;
      bt.nums = n;
      bt.mode = m;
      rs.idx  = r;
      rs.res  = res;
      rs.err  = err;
      exp_beats.push_back(bt);
      exp_rsp.push_back(rs);
   endtask

   // Offer BL beats from requester r; gap idle cycles between accepted beats.
   task automatic drive_job(input int r, input logic [15:0] nums, input logic [1:0] m,
                            input int gap);
      for (int b = 0; b < BL; b++) begin
         int guard;
         guard    = 0;
         req_v[r] = 1'b1;
         req_n[r] = nums[4*b +: 4];
         req_m[r] = m;
         while (rq_ready[r] !== 1'b1 && guard < 400) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 400) begin
            chk_eq("ready_wait", rq_ready[r], 1);
            req_v[r] = 1'b0;
            return;
         end
         chk_eq("owner_load", owner, r);
         last_acc_cyc = cyc;
         @(negedge clk);
         if (gap > 0 && b < BL - 1) begin
            req_v[r] = 1'b0;
            req_n[r] = '0;
            repeat (gap) @(negedge clk);
         end
      end
      req_v[r] = 1'b0;
      req_n[r] = '0;
      req_m[r] = '0;
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (exp_rsp.size() != 0 && g < 600) begin
         @(negedge clk);
         g++;
      end
      chk_eq("drain", exp_rsp.size(), 0);
      repeat (2) @(negedge clk);
      chk_eq("busy_idle", busy, 0);
      chk_eq("owner_idle", owner, 0);
   endtask

   // Engine model: checks the burst, answers eng_lat cycles after its last beat.
   initial begin
      int                nb;
      int                cd;
      logic signed [6:0] acc;
      beat_t             cur;
      nb  = 0;
      cd  = 0;
      acc = '0;
      cur.nums = '0;
      cur.mode = '0;
      eng_out_valid  = 1'b0;
      eng_out_result = '0;
      forever begin
         @(negedge clk);
         eng_out_valid = 1'b0;
         if (rst) begin
            nb = 0;
            cd = 0;
         end else begin
            if (cd > 0) begin
               cd--;
               if (cd == 0 && !eng_silent) begin
                  eng_out_valid  = 1'b1;
                  eng_out_result = ovr_en ? ovr_val : acc;
                  last_eov_cyc   = cyc;
               end
            end
            if (nb > 0) chk_eq("eng_contig", eng_in_valid, 1);
            if (eng_in_valid) begin
               if (nb == 0) begin
                  acc = '0;
                  if (exp_beats.size() == 0) chk_eq("eng_unexp_burst", exp_beats.size(), 1);
                  else cur = exp_beats.pop_front();
                  chk_eq("send_start", cyc, last_acc_cyc + 1);
               end
               chk_eq("eng_num", eng_in_number, cur.nums[4*nb +: 4]);
               chk_eq("eng_mode", eng_mode, cur.mode);
               acc = acc + 7'(eng_in_number);
               nb++;
               if (nb == BL) begin
                  nb = 0;
                  cd = eng_lat;
               end
            end else begin
               chk_eq("eng_idle_zero", {eng_in_number, eng_mode}, 0);
            end
         end
      end
   end

   // Response scoreboard and ready exclusivity monitor.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (rq_ready != '0) chk_eq("ready_onehot", $onehot(rq_ready), 1);
         if (rsp_valid != '0) begin
            if (exp_rsp.size() == 0) begin
               chk_eq("rsp_unexpected", rsp_valid, 0);
            end else begin
               e = exp_rsp.pop_front();
               chk_eq("rsp_valid", rsp_valid, 1 << e.idx);
               chk_eq("rsp_result", rsp_result, e.res);
               chk_eq("rsp_err", rsp_err, e.err);
               if (!e.err) chk_eq("rsp_latency", cyc - last_eov_cyc, 1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         req_v[i] = 1'b0;
         req_n[i] = '0;
         req_m[i] = '0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      chk_eq("rst_rq_ready", rq_ready, 0);
      chk_eq("rst_rsp_valid", rsp_valid, 0);
      chk_eq("rst_rsp_result", rsp_result, 0);
      chk_eq("rst_rsp_err", rsp_err, 0);
      chk_eq("rst_eng_valid", eng_in_valid, 0);
      chk_eq("rst_eng_num", eng_in_number, 0);
      chk_eq("rst_eng_mode", eng_mode, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_owner", owner, 0);

      // Round-robin: both requesters request from reset; service 0,1,0,1
      push_job(0, 16'h4321, 2'd1, sum_of(16'h4321), 1'b0);
      push_job(1, 16'h1111, 2'd3, sum_of(16'h1111), 1'b0);
      push_job(0, 16'hF0F0, 2'd0, sum_of(16'hF0F0), 1'b0);
      push_job(1, 16'h8765, 2'd2, sum_of(16'h8765), 1'b0);
      fork
         begin
            drive_job(0, 16'h4321, 2'd1, 0);
            drive_job(0, 16'hF0F0, 2'd0, 0);
         end
         begin
            drive_job(1, 16'h1111, 2'd3, 0);
            drive_job(1, 16'h8765, 2'd2, 0);
         end
         begin
            @(negedge clk);
            rst = 1'b0;
         end
      join
      wait_done();

      // Single job: 3,5,7,9 mode 2 -> 24
      eng_lat = 2;
      push_job(0, 16'h9753, 2'd2, 7'sd24, 1'b0);
      drive_job(0, 16'h9753, 2'd2, 0);
      wait_done();

      // Gapped load from requester 1: 1,2,4,8 mode 1, two idle cycles between beats
      eng_lat = 3;
      push_job(1, 16'h8421, 2'd1, 7'sd15, 1'b0);
      drive_job(1, 16'h8421, 2'd1, 2);
      wait_done();

      // Negative result passes through untouched
      eng_lat = 1;
      ovr_en  = 1'b1;
      ovr_val = -7'sd63;
      push_job(0, 16'h2222, 2'd0, 7'sb100_0001, 1'b0);
      drive_job(0, 16'h2222, 2'd0, 0);
      wait_done();
      ovr_en  = 1'b0;
      eng_lat = 2;

      // Reset during SEND beat 2 discards the job
      push_job(1, 16'h3333, 2'd3, sum_of(16'h3333), 1'b0);
      drive_job(1, 16'h3333, 2'd3, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_eq("mid_rst_eng_valid", eng_in_valid, 0);
      chk_eq("mid_rst_eng_num", eng_in_number, 0);
      chk_eq("mid_rst_eng_mode", eng_mode, 0);
      chk_eq("mid_rst_rsp_valid", rsp_valid, 0);
      chk_eq("mid_rst_busy", busy, 0);
      chk_eq("mid_rst_owner", owner, 0);
      chk_eq("mid_rst_rq_ready", rq_ready, 0);
      exp_rsp.delete();
      exp_beats.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // After reset ptr is 0: simultaneous requests serve 0 then 1
      push_job(0, 16'h1234, 2'd2, sum_of(16'h1234), 1'b0);
      push_job(1, 16'h5555, 2'd1, sum_of(16'h5555), 1'b0);
      fork
         drive_job(0, 16'h1234, 2'd2, 0);
         drive_job(1, 16'h5555, 2'd1, 0);
      join
      wait_done();

`ifdef LAB06_ARB_TIMEOUT_EN
      // Engine silent: substitute -64 with rsp_err after TMO wait cycles
      eng_silent = 1'b1;
      push_job(0, 16'h1111, 2'd1, 7'sb100_0000, 1'b1);
      drive_job(0, 16'h1111, 2'd1, 0);
      wait_done();
      eng_silent = 1'b0;

      // Engine answers on the expiry cycle: real result wins
      eng_lat = TMO;
      push_job(1, 16'h2121, 2'd2, sum_of(16'h2121), 1'b0);
      drive_job(1, 16'h2121, 2'd2, 0);
      wait_done();
      eng_lat = 2;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lab06_arbiter.md
# lab06_arbiter

Round-robin scheduler that shares one lab06 compute engine (4-bit number burst + 2-bit mode in, one signed 7-bit result out) between up to four requesters.
- Each requester's burst is collected into a local buffer, then replayed to the engine as one contiguous in_valid burst.
- The block waits for the engine's out_valid and returns the result to the owning requester.
- It sits between the lab06 compute engine and its clients, and is the only block that drives the engine inputs.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..4)
- BURST_LEN, 4, numbers per job (2..8)
- TIMEOUT, 64, engine-response watchdog limit in cycles; used only with LAB06_ARB_TIMEOUT_EN

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- rq_valid  in  NREQ  requester i offers a number this cycle
- rq_ready  out  NREQ  arbiter accepts requester i's number this cycle
- rq_number  in  NREQ*4  requester i's number in bits [4i+3:4i], unsigned
- rq_mode  in  NREQ*2  requester i's mode in bits [2i+1:2i]; sampled on the first accepted beat
- rsp_valid  out  NREQ  one-cycle result pulse to requester i
- rsp_result  out  7  signed result; valid only while any rsp_valid bit is 1
- rsp_err  out  1  result is a timeout substitute; qualifies rsp_valid
- eng_in_valid  out  1  engine in_valid
- eng_in_number  out  4  engine in_number
- eng_mode  out  2  engine mode
- eng_out_valid  in  1  engine out_valid
- eng_out_result  in  7  engine out_result, signed
- busy  out  1  high in every state except IDLE
- owner  out  2  index of the current owner; 0 in IDLE

## Operation
FSM states are IDLE, LOAD, SEND, WAIT and RESP. Every output is registered.

- **IDLE**
  - Pick the first i with rq_valid[i]=1, scanning circularly from the priority pointer `ptr`.
  - Latch owner=i. Next state is LOAD.
  - If no request is pending, stay in IDLE.
- **LOAD**
  - rq_ready[owner]=1; all other rq_ready bits are 0.
  - A beat is accepted when rq_valid&rq_ready for the owner. It is written to buf[cnt] and cnt increments.
  - Mode is captured on beat 0.
  - Gaps in rq_valid are allowed; LOAD simply waits.
  - After beat BURST_LEN-1 is accepted: rq_ready drops, cnt=0, next state is SEND.
- **SEND**
  - For exactly BURST_LEN consecutive cycles: eng_in_valid=1, eng_in_number=buf[cnt], and eng_mode = captured mode.
  - Outside SEND, eng_in_valid, eng_in_number and eng_mode are all 0.
  - Next state is WAIT.
- **WAIT**
  - Hold until eng_out_valid=1, then latch eng_out_result. Next state is RESP.
  - eng_out_valid seen in any other state is ignored.
- **RESP**
  - rsp_valid[owner]=1 for one cycle, with rsp_result and rsp_err driven.
  - ptr=(owner+1) mod NREQ. Next state is IDLE.
- **Arithmetic:** the result is passed through unmodified as 7-bit two's complement. No widening and no saturation.

## Timing
- **Reset:**
  - All outputs are 0; state=IDLE, ptr=0, cnt=0; buffer contents are don't-care.
  - A reset asserted mid-job discards the job: no rsp_valid is issued and eng_in_valid drops the next cycle.
- **Handshake:**
  - A request seen in IDLE at cycle t gives rq_ready[owner]=1 from cycle t+1.
  - The first SEND beat appears the cycle after the last accepted beat.
  - rsp_valid appears the cycle after eng_out_valid.
- **Minimum latency:** with the engine responding in L cycles after its last beat, the first accepted beat to rsp_valid takes 2*BURST_LEN+L+1 cycles.
- **Fairness:** a requester that just finished has lowest priority. Simultaneous requests in IDLE resolve by scan order from ptr.
- **Exclusivity:** only one job is in flight at a time. Requests arriving while busy=1 wait; rq_ready stays 0 for them.

## Configuration
- **LAB06_ARB_TIMEOUT_EN defined:**
  - A WAIT cycle counter runs. If it reaches TIMEOUT without eng_out_valid, the FSM goes to RESP with rsp_result=7'sb1000000 (-64) and rsp_err=1.
  - eng_out_valid on the expiry cycle wins: the real result is returned with rsp_err=0.
  - A late eng_out_valid after a timeout is ignored.
- **Undefined:** WAIT waits indefinitely, there is no counter logic, and rsp_err is tied to 0.

## Structure
- Package lab06_arb_pkg holds:
  - the state enum (IDLE/LOAD/SEND/WAIT/RESP),
  - the width constants NUM_W=4, MODE_W=2, RES_W=7,
  - the timeout substitute value RES_TIMEOUT=-64.
- One sub-module, lab06_rr_pick: a combinational circular priority picker with inputs req[NREQ] and ptr, and outputs gnt_valid and gnt_idx.

## Test plan
- **Single job:** requester 0 sends 3,5,7,9 with mode=2 and the engine model returns 24 after 2 cycles -> eng_in_valid is high 4 consecutive cycles with numbers 3,5,7,9 and mode 2; rsp_valid[0] pulses once with rsp_result=24; busy returns to 0.
- **Round-robin:** both requesters hold rq_valid from reset -> served in order 0, 1, 0, 1; no rq_ready while busy.
- **Gapped load:** requester 1 inserts 2 idle cycles between beats -> the engine burst is still 4 contiguous cycles with the correct order.
- **Negative result:** the engine returns -63 -> rsp_result=7'b1000001, rsp_err=0.
- **Reset mid-SEND:** rst asserted during beat 2 -> all outputs 0 next cycle, no rsp_valid, and the next job starts with ptr=0.
- **Timeout (LAB06_ARB_TIMEOUT_EN, TIMEOUT=8):** the engine never responds -> rsp_valid with rsp_result=-64 and rsp_err=1 after 8 WAIT cycles. A second run with eng_out_valid on cycle 8 returns the real result with rsp_err=0.
